// File: rtl/clause_trav_pkg.sv
// Shared types for the clause traversal unit: FSM states, clause classes and
// helpers that locate the per-literal flag bits inside a clause word.
package clause_trav_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_EVAL,
    S_IMPL,
    S_DONE
  } trav_state_t;

  typedef enum logic [1:0] {
    SATISFIED,
    CONFLICT,
    UNIT,
    OPEN
  } clause_class_t;

  // Flag triple sitting just above the variable id in each literal slot.
  typedef struct packed {
    logic sign;
    logic assigned;
    logic val;
  } lit_flags_t;

  function automatic int slot_lsb(input int slot, input int lit_w);
    return slot * lit_w;
  endfunction

  function automatic int flags_lsb(input int slot, input int var_w);
    return slot * (var_w + 3) + var_w;
  endfunction

endpackage

// File: rtl/clause_eval.sv
// Combinational clause classifier: satisfied / conflict / unit / open, plus
// the implied variable and value when exactly one literal is left unassigned.
module clause_eval
  import clause_trav_pkg::*;
#(
  parameter int NLIT  = 4,
  parameter int VAR_W = 10,
  localparam int LIT_W = VAR_W + 3
) (
  input  logic [NLIT*LIT_W-1:0] i_slots,
  output logic [1:0]            o_class,
  output logic [VAR_W-1:0]      o_unit_var,
  output logic                  o_unit_value
);

  lit_flags_t    w_f;
  logic          w_any_true;
  logic [1:0]    w_n_unas;
  clause_class_t w_class;

  always_comb begin
    w_f          = '0;
    w_any_true   = 1'b0;
    w_n_unas     = 2'd0;
    o_unit_var   = '0;
    o_unit_value = 1'b0;
    for (int i = 0; i < NLIT; i++) begin
      w_f = lit_flags_t'(i_slots[flags_lsb(i, VAR_W) +: 3]);
      if (w_f.assigned && (w_f.val != w_f.sign)) w_any_true = 1'b1;
      // Unassigned count saturates at 2: only 0, 1 and "more" matter.
      if (!w_f.assigned) begin
        if (w_n_unas != 2'd2) w_n_unas = w_n_unas + 2'd1;
        o_unit_var   = i_slots[slot_lsb(i, LIT_W) +: VAR_W];
        o_unit_value = ~w_f.sign;
      end
    end
    if (w_any_true)              w_class = SATISFIED;
    else if (w_n_unas == 2'd0)   w_class = CONFLICT;
    else if (w_n_unas == 2'd1)   w_class = UNIT;
    else                         w_class = OPEN;
  end

  assign o_class = w_class;

endmodule

// File: rtl/clause_traversal_unit.sv
// Walks a linked list of clauses after a variable assignment: read, write back
// the assignment, classify, emit implications, and stop on conflict or end.
module clause_traversal_unit
  import clause_trav_pkg::*;
#(
  parameter int NLIT   = 4,
  parameter int VAR_W  = 10,
  parameter int ADDR_W = 12,
  localparam int OFF_W  = $clog2(NLIT),
  localparam int LIT_W  = VAR_W + 3,
  localparam int WORD_W = ADDR_W + OFF_W + NLIT * LIT_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_head_addr,
  input  logic [OFF_W-1:0]  i_head_off,
  input  logic              i_value,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  input  logic [WORD_W-1:0] i_mem_rdata,
  output logic              o_impl_valid,
  input  logic              i_impl_ready,
  output logic [VAR_W-1:0]  o_impl_var,
  output logic              o_impl_value,
  output logic              o_busy,
  output logic              o_finish,
  output logic              o_conflict,
  output logic [2:0]        o_dbg_state
);

  // Implication handshake: a transfer happens on a rising edge where
  // o_impl_valid and i_impl_ready are both 1; until then o_impl_var and
  // o_impl_value stay constant and o_impl_valid never drops.

  trav_state_t       r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [OFF_W-1:0]  r_off;
  logic              r_value;
  logic              r_conf_pend;
  logic [WORD_W-1:0] r_word;

  logic [WORD_W-1:0] w_updated;
  logic [ADDR_W-1:0] w_next_ptr;
  logic [OFF_W-1:0]  w_next_off;
  logic [1:0]        w_class;
  logic [VAR_W-1:0]  w_unit_var;
  logic              w_unit_value;
  logic              w_advance;

  // Fresh read data with the assigned slot's flags overwritten; this is both
  // the write-back word and the word that gets classified.
  always_comb begin
    w_updated = i_mem_rdata;
    for (int i = 0; i < NLIT; i++) begin
      if (r_off == OFF_W'(i)) begin
        w_updated[flags_lsb(i, VAR_W) + 1] = 1'b1;
        w_updated[flags_lsb(i, VAR_W)]     = r_value;
      end
    end
  end

  assign w_next_ptr = r_word[WORD_W-1 -: ADDR_W];
  assign w_next_off = r_word[WORD_W-ADDR_W-1 -: OFF_W];

  clause_eval #(
    .NLIT  (NLIT),
    .VAR_W (VAR_W)
  ) u_eval (
    .i_slots      (r_word[NLIT*LIT_W-1:0]),
    .o_class      (w_class),
    .o_unit_var   (w_unit_var),
    .o_unit_value (w_unit_value)
  );

  assign w_advance = ((r_state == S_EVAL) && (w_class == SATISFIED || w_class == OPEN)) ||
                     ((r_state == S_IMPL) && i_impl_ready);

  assign o_dbg_state = r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_off        <= '0;
      r_value      <= 1'b0;
      r_conf_pend  <= 1'b0;
      r_word       <= '0;
      o_mem_re     <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_impl_valid <= 1'b0;
      o_impl_var   <= '0;
      o_impl_value <= 1'b0;
      o_busy       <= 1'b0;
      o_finish     <= 1'b0;
      o_conflict   <= 1'b0;
    end else begin
      o_mem_re   <= 1'b0;
      o_mem_we   <= 1'b0;
      o_finish   <= 1'b0;
      o_conflict <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr      <= i_head_addr;
            r_off       <= i_head_off;
            r_value     <= i_value;
            r_conf_pend <= 1'b0;
            o_busy      <= 1'b1;
            if (i_head_addr == '0) begin
              o_finish <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              o_mem_re   <= 1'b1;
              o_mem_addr <= i_head_addr;
              r_state    <= S_READ;
            end
          end
        end
        S_READ: r_state <= S_WAIT;
        S_WAIT: begin
          r_word      <= w_updated;
          o_mem_wdata <= w_updated;
          o_mem_we    <= 1'b1;
          r_state     <= S_EVAL;
        end
        S_EVAL: begin
          if (w_class == CONFLICT) begin
            r_conf_pend <= 1'b1;
            o_finish    <= 1'b1;
            o_conflict  <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_class == UNIT) begin
            o_impl_valid <= 1'b1;
            o_impl_var   <= w_unit_var;
            o_impl_value <= w_unit_value;
            r_state      <= S_IMPL;
          end
        end
        S_IMPL: ;
        S_DONE: begin
          r_conf_pend <= 1'b0;
          o_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Shared exit for non-conflicting clauses; a pointer equal to the
      // current address is followed like any other.
      if (w_advance) begin
        r_addr       <= w_next_ptr;
        r_off        <= w_next_off;
        o_impl_valid <= 1'b0;
        if (w_next_ptr == '0) begin
          o_finish   <= 1'b1;
          o_conflict <= r_conf_pend;
          r_state    <= S_DONE;
        end else begin
          o_mem_re   <= 1'b1;
          o_mem_addr <= w_next_ptr;
          r_state    <= S_READ;
        end
      end
    end
  end

endmodule

// File: tb/tb_clause_traversal_unit.sv
// Bench for clause_traversal_unit: small clause memory, reference list walker
// feeding an expected-event queue, vector table plus hand-written sequences.
module tb_clause_traversal_unit;
  import clause_trav_pkg::*;

  localparam int NLIT   = 4;
  localparam int VAR_W  = 10;
  localparam int ADDR_W = 12;
  localparam int OFF_W  = 2;
  localparam int LIT_W  = 13;
  localparam int WORD_W = 66;
  localparam int EV_W   = 2 + ADDR_W + WORD_W;
  localparam logic [1:0] EV_RD = 2'd0, EV_WR = 2'd1, EV_IMPL = 2'd2, EV_FIN = 2'd3;
  localparam int NV = 11;

  logic              clk, i_rst, i_start, i_value, i_impl_ready;
  logic [ADDR_W-1:0] i_head_addr;
  logic [OFF_W-1:0]  i_head_off;
  logic [WORD_W-1:0] i_mem_rdata;
  logic              o_mem_re, o_mem_we, o_impl_valid, o_impl_value, o_busy, o_finish, o_conflict;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [WORD_W-1:0] o_mem_wdata;
  logic [VAR_W-1:0]  o_impl_var;
  logic [2:0]        o_dbg_state;

  clause_traversal_unit #(.NLIT(NLIT), .VAR_W(VAR_W), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_head_addr(i_head_addr),
    .i_head_off(i_head_off), .i_value(i_value), .o_mem_re(o_mem_re), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_impl_valid(o_impl_valid), .i_impl_ready(i_impl_ready), .o_impl_var(o_impl_var),
    .o_impl_value(o_impl_value), .o_busy(o_busy), .o_finish(o_finish),
    .o_conflict(o_conflict), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int   scen;
    int   head;
    int   off;
    logic value;
    int   exp_conf;    // -1: not fixed by the table
    int   exp_cycles;  // START edge to FINISH sample; 0: not fixed
    int   poke_cycle;  // nonzero: pulse START again after this many cycles
    logic rdy_rand;
  } vec_t;

  vec_t              vecs[NV];
  logic [WORD_W-1:0] mem[16];
  logic [WORD_W-1:0] mdl[16];
  logic [EV_W-1:0]   exp_q[$];
  int                n_vec = 0, n_miss = 0;
  logic              prev_re, rdy_rand, fin_seen, fin_conf;

  function automatic logic [EV_W-1:0] ev(input logic [1:0] t, input logic [ADDR_W-1:0] a,
                                         input logic [WORD_W-1:0] d);
    return {t, a, d};
  endfunction

  function automatic logic [LIT_W-1:0] mk_lit(input logic s, input logic a, input logic v, input int id);
    return {s, a, v, VAR_W'(id)};
  endfunction

  function automatic logic [WORD_W-1:0] mk_word(input int nx, input int noff,
      input logic [LIT_W-1:0] l3, input logic [LIT_W-1:0] l2,
      input logic [LIT_W-1:0] l1, input logic [LIT_W-1:0] l0);
    return {ADDR_W'(nx), OFF_W'(noff), l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [EV_W-1:0] act, input logic [EV_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_event(input string name, input logic [EV_W-1:0] act);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL %s: got event %0h, expected no event", name, act);
    end else begin
      logic [EV_W-1:0] e;
      e = exp_q.pop_front();
      if (e !== act) begin
        n_miss++;
        $display("FAIL %s: got event %0h, expected %0h", name, act, e);
      end
    end
  endtask

  // One clock: log a handshake due at the coming edge, then sample at the
  // falling edge and play the memory (read data valid the cycle after MEM_RE).
  task automatic cycle();
    if (o_impl_valid && i_impl_ready)
      sb_event("impl", ev(EV_IMPL, '0, WORD_W'({o_impl_var, o_impl_value})));
    @(negedge clk);
    fin_seen = 1'b0;
    if (o_mem_re && o_mem_we) begin
      n_vec++;
      n_miss++;
      $display("FAIL re_we_overlap: got re=1 we=1, expected at most one");
    end
    if (o_mem_re) begin
      sb_event("read", ev(EV_RD, o_mem_addr, '0));
      i_mem_rdata = mem[o_mem_addr[3:0]];
    end else if (!prev_re) begin
      i_mem_rdata = WORD_W'({$urandom(), $urandom(), $urandom()});
    end
    prev_re = o_mem_re;
    if (o_mem_we) begin
      sb_event("write", ev(EV_WR, o_mem_addr, o_mem_wdata));
      mem[o_mem_addr[3:0]] = o_mem_wdata;
    end
    if (o_finish) begin
      sb_event("finish", ev(EV_FIN, '0, WORD_W'(o_conflict)));
      fin_seen = 1'b1;
      fin_conf = o_conflict;
    end
    if (rdy_rand) i_impl_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic load_scen(input int id, output int rnd_head);
    logic [LIT_W-1:0] f, l[4];
    int a[3], n, nx;
    f = mk_lit(1'b1, 1'b1, 1'b1, 30);
    rnd_head = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    case (id)
      2: begin
        mem[5] = mk_word(9, 1, f, f, mk_lit(0, 1, 1, 2), mk_lit(0, 0, 0, 1));
        mem[9] = mk_word(0, 0, mk_lit(0, 0, 0, 23), mk_lit(1, 0, 0, 22),
                         mk_lit(0, 0, 0, 4), mk_lit(1, 1, 0, 8));
      end
      3: mem[5] = mk_word(0, 0, f, f, mk_lit(1, 0, 0, 7), mk_lit(0, 0, 0, 3));
      4: begin
        mem[5] = mk_word(9, 0, f, f, f, mk_lit(0, 0, 0, 5));
        mem[9] = mk_word(0, 0, f, f, f, mk_lit(0, 1, 1, 6));
      end
      5: begin
        mem[3] = mk_word(6, 2, f, f, mk_lit(0, 0, 0, 11), mk_lit(1, 0, 0, 10));
        mem[6] = mk_word(0, 0, mk_lit(1, 0, 0, 23), mk_lit(0, 0, 0, 22),
                         mk_lit(1, 0, 0, 21), mk_lit(0, 0, 0, 20));
      end
      6: mem[4] = mk_word(4, 1, f, f, mk_lit(0, 0, 0, 13), mk_lit(0, 0, 0, 12));
      7: begin
        n = $urandom_range(1, 3);
        a[0] = $urandom_range(1, 5);
        a[1] = $urandom_range(6, 10);
        a[2] = $urandom_range(11, 15);
        for (int c = 0; c < n; c++) begin
          nx = (c == n - 1) ? 0 : a[c + 1];
          for (int j = 0; j < 4; j++)
            l[j] = mk_lit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 1023));
          mem[a[c]] = mk_word(nx, $urandom_range(0, 3), l[3], l[2], l[1], l[0]);
        end
        rnd_head = a[0];
      end
      default: ;
    endcase
    for (int i = 0; i < 16; i++) mdl[i] = mem[i];
  endtask

  // Reference walk over a private copy of the memory image.
  task automatic model_run(input int addr, input int off, input logic value);
    logic [WORD_W-1:0] w;
    logic              s, a, v, conf;
    int                nt, nu, ui, steps;
    conf  = 1'b0;
    steps = 0;
    while (addr != 0 && steps < 20) begin
      steps++;
      exp_q.push_back(ev(EV_RD, ADDR_W'(addr), '0));
      w = mdl[addr];
      w[off * LIT_W + VAR_W + 1] = 1'b1;
      w[off * LIT_W + VAR_W]     = value;
      mdl[addr] = w;
      exp_q.push_back(ev(EV_WR, ADDR_W'(addr), w));
      nt = 0; nu = 0; ui = 0;
      for (int i = 0; i < NLIT; i++) begin
        s = w[i * LIT_W + VAR_W + 2];
        a = w[i * LIT_W + VAR_W + 1];
        v = w[i * LIT_W + VAR_W];
        if (a && v != s) nt++;
        if (!a) begin nu++; ui = i; end
      end
      if (nt == 0 && nu == 0) begin
        conf = 1'b1;
        break;
      end
      if (nt == 0 && nu == 1)
        exp_q.push_back(ev(EV_IMPL, '0, WORD_W'({w[ui * LIT_W +: VAR_W], ~w[ui * LIT_W + VAR_W + 2]})));
      addr = int'(w[WORD_W-1 -: ADDR_W]);
      off  = int'(w[WORD_W-ADDR_W-1 -: OFF_W]);
    end
    exp_q.push_back(ev(EV_FIN, '0, WORD_W'(conf)));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_outs"}, {o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata}, '0);
    chk({tag, "_ctl_outs"}, EV_W'({o_impl_valid, o_impl_var, o_impl_value, o_busy, o_finish, o_conflict}), '0);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_leftover_events"}, EV_W'(exp_q.size()), '0);
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   head, rh, k;
    logic done, conf;
    load_scen(v.scen, rh);
    head = (v.scen == 7) ? rh : v.head;
    model_run(head, v.off, v.value);
    rdy_rand = v.rdy_rand;
    if (!v.rdy_rand) i_impl_ready = 1'b1;
    i_head_addr = ADDR_W'(head);
    i_head_off  = OFF_W'(v.off);
    i_value     = v.value;
    i_start     = 1'b1;
    k = 0; done = 1'b0; conf = 1'b0;
    while (!done && k < 300) begin
      cycle();
      k++;
      i_start = (v.poke_cycle != 0 && k == v.poke_cycle);
      if (i_start) begin
        i_head_addr = '0;
        i_head_off  = ~i_head_off;
      end
      if (fin_seen) begin
        done = 1'b1;
        conf = fin_conf;
      end
    end
    i_start = 1'b0;
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: got no FINISH in %0d cycles, expected FINISH", tag, k);
    end else begin
      if (v.exp_conf >= 0) chk({tag, "_conflict"}, EV_W'(conf), EV_W'(v.exp_conf));
      if (v.exp_cycles > 0) chk({tag, "_latency"}, EV_W'(k), EV_W'(v.exp_cycles));
    end
    drain(tag);
    cycle();
    chk({tag, "_busy_after"}, EV_W'(o_busy), '0);
  endtask

  initial begin
    int               h, k;
    logic [WORD_W-1:0] saved;
    i_rst = 1'b1; i_start = 1'b0; i_value = 1'b0; i_impl_ready = 1'b0;
    i_head_addr = '0; i_head_off = '0; i_mem_rdata = '0;
    prev_re = 1'b0; rdy_rand = 1'b0; fin_seen = 1'b0; fin_conf = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    vecs[0] = '{1, 0, 0, 1'b0, 0, 1, 0, 1'b0};
    vecs[1] = '{2, 5, 0, 1'b1, 0, 7, 0, 1'b0};
    vecs[2] = '{4, 5, 0, 1'b0, 1, 4, 0, 1'b1};
    vecs[3] = '{5, 3, 0, 1'b1, 0, 0, 0, 1'b1};
    vecs[4] = '{6, 4, 0, 1'b0, 1, 0, 0, 1'b1};
    vecs[5] = '{2, 5, 0, 1'b1, 0, 7, 3, 1'b0};
    vecs[6] = '{3, 5, 0, 1'b0, 0, 0, 0, 1'b1};
    for (int i = 7; i < NV; i++)
      vecs[i] = '{7, 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1, 0, 0, 1'b1};

    repeat (3) cycle();
    check_all_zero("reset");
    chk("reset_state", EV_W'(o_dbg_state), EV_W'(S_IDLE));
    i_rst = 1'b0;
    cycle();

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Unit clause with a stalled consumer.
    load_scen(3, h);
    model_run(5, 0, 1'b0);
    rdy_rand = 1'b0; i_impl_ready = 1'b0;
    i_head_addr = 12'd5; i_head_off = '0; i_value = 1'b0; i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    k = 0;
    while (!o_impl_valid && k < 20) begin cycle(); k++; end
    chk("impl_first", EV_W'({o_impl_valid, o_impl_var, o_impl_value}), EV_W'({1'b1, 10'd7, 1'b0}));
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("impl_hold%0d", i), EV_W'({o_impl_valid, o_impl_var, o_impl_value}),
          EV_W'({1'b1, 10'd7, 1'b0}));
    end
    i_impl_ready = 1'b1;
    cycle();
    chk("impl_release", EV_W'({o_impl_valid, o_finish}), EV_W'(2'b01));
    i_impl_ready = 1'b0;
    cycle();
    drain("impl_seq");

    // Reset while waiting for read data.
    load_scen(2, h);
    saved = mem[5];
    exp_q.push_back(ev(EV_RD, 12'd5, '0));
    i_impl_ready = 1'b1;
    i_head_addr = 12'd5; i_head_off = '0; i_value = 1'b1; i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    cycle();
    chk("rst_wait_reached", EV_W'(o_dbg_state), EV_W'(S_WAIT));
    i_rst = 1'b1;
    cycle();
    check_all_zero("mid_rst");
    chk("mid_rst_state", EV_W'(o_dbg_state), EV_W'(S_IDLE));
    i_rst = 1'b0;
    cycle();
    check_all_zero("post_rst");
    chk("post_rst_mem5", EV_W'(mem[5]), EV_W'(saved));
    drain("rst_seq");
    run_vec('{2, 5, 0, 1'b1, 0, 7, 0, 1'b0}, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/clause_traversal_unit.md
CLAUSE_TRAVERSAL_UNIT -- requirements
Module: clause_traversal_unit

Interface
REQ-001 SHALL have parameters: NLIT, default 4, literals per clause; VAR_W, default 10, variable-id width; ADDR_W, default 12, clause address width.
REQ-002 SHALL derive OFF_W=$clog2(NLIT), LIT_W=VAR_W+3, WORD_W=ADDR_W+OFF_W+NLIT*LIT_W (66 at defaults).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 CLK  in  1  clock; RST  in  1  synchronous active-high reset.
REQ-005 START  in  1  begin traversal; HEAD_ADDR  in  ADDR_W  first clause; HEAD_OFF  in  OFF_W  slot of the assigned variable in the first clause; VALUE  in  1  value assigned to that variable.
REQ-006 MEM_RE  out  1  read strobe; MEM_WE  out  1  write strobe; MEM_ADDR  out  ADDR_W  address; MEM_WDATA  out  WORD_W  write data; MEM_RDATA  in  WORD_W  read data, valid exactly one cycle after MEM_RE.
REQ-007 IMPL_VALID  out  1  implication present; IMPL_READY  in  1  consumer accept; IMPL_VAR  out  VAR_W  implied variable; IMPL_VALUE  out  1  implied value.
REQ-008 BUSY  out  1  traversal active; FINISH  out  1  one-cycle completion pulse; CONFLICT  out  1  conflict flag, valid only while FINISH=1.

Function
REQ-009 Word layout SHALL be: [WORD_W-1 -: ADDR_W] next pointer, then OFF_W next offset, then slot i at [i*LIT_W +: LIT_W] = {sign, assigned, val, var}. Next pointer 0 means end of list.
REQ-010 A literal SHALL be true iff assigned=1 and val!=sign; false iff assigned=1 and val==sign; otherwise unassigned.
REQ-011 FSM states SHALL be IDLE, READ, WAIT, EVAL, IMPL, DONE.
REQ-012 IDLE: if START=1, latch HEAD_ADDR, HEAD_OFF and VALUE. Go to DONE if HEAD_ADDR==0, otherwise to READ. START outside IDLE SHALL be ignored.
REQ-013 READ: MEM_RE=1, MEM_ADDR=current address, then go to WAIT. WAIT: capture MEM_RDATA, then go to EVAL.
REQ-014 EVAL: set slot[offset].assigned=1 and slot[offset].val=latched VALUE; drive MEM_WE=1, MEM_ADDR=current address, MEM_WDATA=updated word. Classify the updated word in the same cycle.
REQ-015 Classification SHALL be: any true literal -> satisfied; no true and zero unassigned -> conflict; no true and exactly one unassigned -> unit; otherwise open.
REQ-016 From EVAL: conflict goes to DONE with CONFLICT pending, and SHALL issue no further reads. Unit goes to IMPL. Satisfied or open advances address/offset to the word's next pointer/offset, then goes to DONE if the pointer is 0, otherwise to READ.
REQ-017 IMPL: IMPL_VALID=1, IMPL_VAR=unassigned slot's var, IMPL_VALUE=~sign. Outputs SHALL be held stable until IMPL_VALID&&IMPL_READY. On handshake, advance as for open.
REQ-018 DONE: FINISH=1 for one cycle, CONFLICT=1 if pending, then go to IDLE. The conflict pending flag SHALL clear on leaving DONE.
REQ-019 BUSY SHALL be 1 in every state except IDLE.
REQ-020 Latency per non-unit clause SHALL be exactly 3 cycles. MEM_RE and MEM_WE SHALL never be high together.
REQ-021 A next pointer equal to the current address SHALL still be followed. Loop avoidance is the memory builder's responsibility.

Reset
REQ-022 RST SHALL force IDLE in the next cycle, from any state and mid-traversal, with no write-back issued.
REQ-023 Under reset all outputs SHALL be 0, and the latched address, offset, value and conflict flag SHALL be cleared.

Structure
REQ-024 The shared package clause_trav_pkg SHALL hold the state enum, the class enum {SATISFIED, CONFLICT, UNIT, OPEN} and the literal field struct/offset functions.
REQ-025 Classification SHALL be the combinational sub-module clause_eval (word in; class, unit var and unit value out). All sequencing SHALL remain in clause_traversal_unit.

Verification
REQ-026 HEAD_ADDR=0, START=1 -> FINISH pulses on the next cycle with CONFLICT=0, and no MEM_RE or MEM_WE.
REQ-027 Two-clause list 5->9->0, both clauses already containing a true literal, VALUE=1 -> reads at 5 and 9, write-backs at 5 and 9, FINISH 6 cycles after START+1, CONFLICT=0.
REQ-028 Clause at 5, slots {var3 pos unassigned, var7 neg unassigned, two false}, HEAD_OFF=0, VALUE=0 -> IMPL_VALID with IMPL_VAR=7, IMPL_VALUE=0. Outputs hold through 4 cycles of IMPL_READY=0 and resume on the cycle after IMPL_READY=1.
REQ-029 Clause at 5 with only slot 0 unassigned, HEAD_OFF=0 and the value making it false, next pointer 9 -> FINISH with CONFLICT=1, and no read at 9.
REQ-030 RST asserted during WAIT -> no MEM_WE follows, all outputs 0, and a new START is accepted.
REQ-031 START pulsed while BUSY=1 -> no effect, and the latched HEAD_ADDR is unchanged.
